// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IFU and LSU share one memory port.
// One outstanding transaction, fair tie-break on the last grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid_i,
  output logic                  ifu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_resp_valid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  ifu_resp_ready_i,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic                  lsu_wen_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [7:0]            lsu_wmask_i,
  output logic                  lsu_resp_valid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  input  logic                  lsu_resp_ready_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_wen_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [7:0]            mem_wmask_o,
  input  logic                  mem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_resp_ready_o,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  // owner/last: 1 = LSU, 0 = IFU
  logic owner;
  logic owner_nx;
  logic last;
  logic last_nx;

  logic                  accept;
  logic                  pick_lsu;
  logic                  resp_rdy;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [7:0]            wmask_q;

  // tie goes to whichever requester was not granted last
  assign pick_lsu = lsu_req_valid_i &&
                    (!ifu_req_valid_i || !last);

  // state, owner and fairness register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
    end
  end

  // next state and all handshake outputs
  always_comb begin
    state_nx         = state;
    owner_nx         = owner;
    last_nx          = last;
    accept           = 1'b0;
    resp_rdy         = 1'b0;
    ifu_req_ready_o  = 1'b0;
    lsu_req_ready_o  = 1'b0;
    ifu_resp_valid_o = 1'b0;
    ifu_rdata_o      = '0;
    lsu_resp_valid_o = 1'b0;
    lsu_rdata_o      = '0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    grant_o          = 2'b00;
    if (rst) begin
      unique case (state)
        IDLE: begin
          ifu_req_ready_o = ifu_req_valid_i && !pick_lsu;
          lsu_req_ready_o = pick_lsu;
          if (ifu_req_valid_i || lsu_req_valid_i) begin
            accept   = 1'b1;
            state_nx = ISSUE;
            owner_nx = pick_lsu;
            last_nx  = pick_lsu;
          end
        end
        ISSUE: begin
          mem_req_valid_o = 1'b1;
          grant_o         = owner ? 2'b10 : 2'b01;
          if (mem_req_ready_i) begin
            state_nx = RESP;
          end
        end
        RESP: begin
          grant_o = owner ? 2'b10 : 2'b01;
          if (owner) begin
            resp_rdy         = lsu_resp_ready_i;
            lsu_resp_valid_o = mem_resp_valid_i;
            if (mem_resp_valid_i) begin
              lsu_rdata_o = mem_rdata_i;
            end
          end else begin
            resp_rdy         = ifu_resp_ready_i;
            ifu_resp_valid_o = mem_resp_valid_i;
            if (mem_resp_valid_i) begin
              ifu_rdata_o = mem_rdata_i;
            end
          end
          mem_resp_ready_o = resp_rdy;
          if (mem_resp_valid_i && resp_rdy) begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // capture the winner's request; IFU is always a word read
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      if (pick_lsu) begin
        addr_q  <= lsu_addr_i;
        wen_q   <= lsu_wen_i;
        wdata_q <= lsu_wdata_i;
        wmask_q <= lsu_wmask_i;
      end else begin
        addr_q  <= ifu_addr_i;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= 8'b0000_1111;
      end
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wen_o   = wen_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vectors
// plus hand sequences for reset-in-flight and latency.
module tb_mem_arbiter;

  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h8000_1000;
  localparam logic [31:0] LD = 32'hDEAD_BEEF;
  localparam logic [7:0]  LM = 8'h03;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid_i, ifu_req_ready_o;
  logic [31:0] ifu_addr_i;
  logic        ifu_resp_valid_o, ifu_resp_ready_i;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_valid_i, lsu_req_ready_o;
  logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic        lsu_wen_i;
  logic [7:0]  lsu_wmask_i;
  logic        lsu_resp_valid_o, lsu_resp_ready_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_wen_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_resp_valid_i, mem_resp_ready_o;
  logic [1:0]  grant_o;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid_i(ifu_req_valid_i),
    .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i),
    .ifu_resp_valid_o(ifu_resp_valid_o),
    .ifu_rdata_o(ifu_rdata_o),
    .ifu_resp_ready_i(ifu_resp_ready_i),
    .lsu_req_valid_i(lsu_req_valid_i),
    .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_addr_i(lsu_addr_i),
    .lsu_wen_i(lsu_wen_i),
    .lsu_wdata_i(lsu_wdata_i),
    .lsu_wmask_i(lsu_wmask_i),
    .lsu_resp_valid_o(lsu_resp_valid_o),
    .lsu_rdata_o(lsu_rdata_o),
    .lsu_resp_ready_i(lsu_resp_ready_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o),
    .mem_wen_o(mem_wen_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_rdata_i(mem_rdata_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, lv, lw, mrr, mrv, irr, lrr;
    logic [31:0] rd;
    logic        ir, lr, mv, mrq;
    logic [1:0]  g;
    logic        ivo, lvo, ew;
  } vec_t;

  vec_t tbl[26];
  int   nchk = 0;
  int   nfail = 0;

  function automatic vec_t mk(
    input logic rs, iv, lv, lw, mrr, mrv, irr, lrr,
    input logic [31:0] rd,
    input logic ir, lr, mv, mrq,
    input logic [1:0] g,
    input logic ivo, lvo, ew);
    vec_t v;
    v.rst = rs; v.iv = iv; v.lv = lv; v.lw = lw;
    v.mrr = mrr; v.mrv = mrv; v.irr = irr;
    v.lrr = lrr; v.rd = rd; v.ir = ir; v.lr = lr;
    v.mv = mv; v.mrq = mrq; v.g = g;
    v.ivo = ivo; v.lvo = lvo; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst              = v.rst;
    ifu_req_valid_i  = v.iv;
    lsu_req_valid_i  = v.lv;
    lsu_wen_i        = v.lw;
    mem_req_ready_i  = v.mrr;
    mem_resp_valid_i = v.mrv;
    ifu_resp_ready_i = v.irr;
    lsu_resp_ready_i = v.lrr;
    mem_rdata_i      = v.rd;
  endtask

  initial begin
    ifu_addr_i  = IA;
    lsu_addr_i  = LA;
    lsu_wdata_i = LD;
    lsu_wmask_i = LM;
    drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0));

    // reset gating and IFU read
    tbl[0]  = mk(0,1,1,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0);
    tbl[1]  = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0);
    tbl[2]  = mk(1,1,0,0,0,0,0,0,0, 1,0,0,0,2'b00,0,0,0);
    tbl[3]  = mk(1,0,0,0,1,0,0,0,0, 0,0,1,0,2'b01,0,0,0);
    tbl[4]  = mk(1,0,0,0,0,1,1,0,32'h413,
                 0,0,0,1,2'b01,1,0,0);
    tbl[5]  = mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0);
    // tie after reset: LSU, then IFU
    tbl[6]  = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0);
    tbl[7]  = mk(1,1,1,0,0,0,0,0,0, 0,1,0,0,2'b00,0,0,0);
    tbl[8]  = mk(1,1,1,0,1,0,0,0,0, 0,0,1,0,2'b10,0,0,0);
    tbl[9]  = mk(1,1,1,0,0,1,0,1,32'h1111_2222,
                 0,0,0,1,2'b10,0,1,0);
    tbl[10] = mk(1,1,1,0,0,0,0,0,0, 1,0,0,0,2'b00,0,0,0);
    tbl[11] = mk(1,1,1,0,1,0,0,0,0, 0,0,1,0,2'b01,0,0,0);
    // response backpressure
    tbl[12] = mk(1,1,1,0,0,1,0,0,32'hAAAA_5555,
                 0,0,0,0,2'b01,1,0,0);
    tbl[13] = mk(1,1,1,0,0,1,0,0,32'hAAAA_5555,
                 0,0,0,0,2'b01,1,0,0);
    tbl[14] = mk(1,1,1,0,0,1,1,0,32'hAAAA_5555,
                 0,0,0,1,2'b01,1,0,0);
    // LSU write with 3 stall cycles
    tbl[15] = mk(1,1,1,1,0,0,0,0,0, 0,1,0,0,2'b00,0,0,0);
    tbl[16] = mk(1,1,1,1,0,0,0,0,0, 0,0,1,0,2'b10,0,0,1);
    tbl[17] = mk(1,1,1,1,0,0,0,0,0, 0,0,1,0,2'b10,0,0,1);
    tbl[18] = mk(1,1,1,1,0,0,0,0,0, 0,0,1,0,2'b10,0,0,1);
    tbl[19] = mk(1,1,1,1,1,0,0,0,0, 0,0,1,0,2'b10,0,0,1);
    tbl[20] = mk(1,0,0,0,0,1,0,1,32'h1234_5678,
                 0,0,0,1,2'b10,0,1,0);
    // reset during ISSUE
    tbl[21] = mk(1,1,0,0,0,0,0,0,0, 1,0,0,0,2'b00,0,0,0);
    tbl[22] = mk(1,0,0,0,0,0,0,0,0, 0,0,1,0,2'b01,0,0,0);
    tbl[23] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0);
    tbl[24] = mk(1,0,0,0,0,1,1,1,32'hFFFF_0000,
                 0,0,0,0,2'b00,0,0,0);
    tbl[25] = mk(1,1,1,0,0,0,0,0,0, 0,1,0,0,2'b00,0,0,0);

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d.ifu_rdy", i),
          64'(ifu_req_ready_o), 64'(tbl[i].ir));
      chk($sformatf("v%0d.lsu_rdy", i),
          64'(lsu_req_ready_o), 64'(tbl[i].lr));
      chk($sformatf("v%0d.mreq_v", i),
          64'(mem_req_valid_o), 64'(tbl[i].mv));
      chk($sformatf("v%0d.mresp_rdy", i),
          64'(mem_resp_ready_o), 64'(tbl[i].mrq));
      chk($sformatf("v%0d.grant", i),
          64'(grant_o), 64'(tbl[i].g));
      chk($sformatf("v%0d.ifu_rv", i),
          64'(ifu_resp_valid_o), 64'(tbl[i].ivo));
      chk($sformatf("v%0d.lsu_rv", i),
          64'(lsu_resp_valid_o), 64'(tbl[i].lvo));
      chk($sformatf("v%0d.ifu_rd", i), 64'(ifu_rdata_o),
          tbl[i].ivo ? 64'(tbl[i].rd) : 64'd0);
      chk($sformatf("v%0d.lsu_rd", i), 64'(lsu_rdata_o),
          tbl[i].lvo ? 64'(tbl[i].rd) : 64'd0);
      if (tbl[i].mv) begin
        if (tbl[i].g == 2'b01) begin
          chk($sformatf("v%0d.addr", i),
              64'(mem_addr_o), 64'(IA));
          chk($sformatf("v%0d.wdata", i),
              64'(mem_wdata_o), 64'd0);
          chk($sformatf("v%0d.wmask", i),
              64'(mem_wmask_o), 64'h0F);
        end else begin
          chk($sformatf("v%0d.addr", i),
              64'(mem_addr_o), 64'(LA));
          chk($sformatf("v%0d.wdata", i),
              64'(mem_wdata_o), 64'(LD));
          chk($sformatf("v%0d.wmask", i),
              64'(mem_wmask_o), 64'(LM));
        end
        chk($sformatf("v%0d.wen", i),
            64'(mem_wen_o), 64'(tbl[i].ew));
      end
    end

    // reset while in RESP abandons the LSU read
    @(negedge clk);
    drive(mk(1,0,0,0,1,0,0,0,0, 0,0,0,0,2'b00,0,0,0));
    #1;
    chk("s1.issue_v", 64'(mem_req_valid_o), 64'd1);
    chk("s1.issue_g", 64'(grant_o), 64'h2);
    @(negedge clk);
    drive(mk(0,0,0,0,0,1,0,1,32'h5A5A_5A5A,
             0,0,0,0,2'b00,0,0,0));
    #1;
    chk("s1.rst_lrv", 64'(lsu_resp_valid_o), 64'd0);
    chk("s1.rst_mrr", 64'(mem_resp_ready_o), 64'd0);
    chk("s1.rst_g", 64'(grant_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s1.post_lrv", 64'(lsu_resp_valid_o), 64'd0);
    chk("s1.post_lrd", 64'(lsu_rdata_o), 64'd0);
    chk("s1.post_g", 64'(grant_o), 64'd0);

    // IFU read with late response; bounded wait for issue
    @(negedge clk);
    drive(mk(1,1,0,0,0,0,0,0,0, 0,0,0,0,2'b00,0,0,0));
    #1;
    chk("s2.ifu_rdy", 64'(ifu_req_ready_o), 64'd1);
    @(negedge clk);
    ifu_req_valid_i = 1'b0;
    #1;
    begin
      int n;
      n = 0;
      while (!mem_req_valid_o && n < 5) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("s2.req_latency", 64'(n), 64'd0);
    end
    @(negedge clk);
    mem_req_ready_i = 1'b1;
    #1;
    chk("s2.req_v", 64'(mem_req_valid_o), 64'd1);
    chk("s2.addr", 64'(mem_addr_o), 64'(IA));
    @(negedge clk);
    mem_req_ready_i  = 1'b0;
    ifu_resp_ready_i = 1'b1;
    #1;
    chk("s2.wait_rv", 64'(ifu_resp_valid_o), 64'd0);
    chk("s2.wait_mrr", 64'(mem_resp_ready_o), 64'd1);
    chk("s2.wait_g", 64'(grant_o), 64'd1);
    @(negedge clk);
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = 32'hCAFE_F00D;
    #1;
    chk("s2.rv", 64'(ifu_resp_valid_o), 64'd1);
    chk("s2.rd", 64'(ifu_rdata_o), 64'hCAFE_F00D);
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    ifu_resp_ready_i = 1'b0;
    #1;
    chk("s2.done_g", 64'(grant_o), 64'd0);
    chk("s2.done_rv", 64'(ifu_resp_valid_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
